// File: rtl/mem_io_responder_pkg.sv
// rtl/mem_io_responder_pkg.sv - shared IO-region constants and access decode for mem_io_responder
package mem_io_responder_pkg;

    localparam logic [1:0] IO_REGION     = 2'b11;
    localparam logic [2:0] IO_OFS_UART   = 3'd0;
    localparam logic [2:0] IO_OFS_SIMEND = 3'd4;
    localparam logic       RW_READ       = 1'b0;
    localparam logic       RW_WRITE      = 1'b1;

    typedef enum logic [1:0] {
        ACC_RAM,
        ACC_UART,
        ACC_SIMEND,
        ACC_NONE
    } acc_t;

    function automatic acc_t decode_acc(input logic [1:0] region, input logic [2:0] ofs);
        if (region != IO_REGION) begin
            return ACC_RAM;
        end
        case (ofs)
            IO_OFS_UART:   return ACC_UART;
            IO_OFS_SIMEND: return ACC_SIMEND;
            default:       return ACC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// rtl/mem_io_responder_byte_fifo.sv - circular byte FIFO; pop is resolved before push so a full FIFO can take a push alongside a pop
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [$clog2(DEPTH):0]     o_next_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;
    logic [PW:0]      w_next_count;

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == FULL_CNT);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign w_next_count = r_count + {{PW{1'b0}}, w_do_push} - {{PW{1'b0}}, w_do_pop};

    assign o_dout       = r_mem[r_head];
    assign o_count      = r_count;
    assign o_next_count = w_next_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_do_push) begin
                r_tail <= r_tail + PW'(1);
            end
            r_count <= w_next_count;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[r_tail] <= i_din;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte RAM plus UART TX/RX FIFOs and sim-end register behind the controller RAM port
// Optional: MEM_IO_UART_LOOKAHEAD_EN raises out_uart_full two entries early.
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8,
    parameter int RX_DEPTH       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        in_rw,
    input  logic [31:0] in_addr,
    input  logic [7:0]  in_wdata,
    output logic [7:0]  out_rdata,
    output logic        out_uart_full,
    output logic        out_tx_valid,
    output logic [7:0]  out_tx_data,
    input  logic        in_tx_ready,
    input  logic        in_rx_valid,
    input  logic [7:0]  in_rx_data,
    output logic        out_sim_end,
    output logic        out_tx_overflow
);

    localparam int TX_CW = $clog2(TX_DEPTH) + 1;
    localparam int RX_CW = $clog2(RX_DEPTH) + 1;
`ifdef MEM_IO_UART_LOOKAHEAD_EN
    localparam logic [TX_CW-1:0] UART_FULL_AT = TX_CW'(TX_DEPTH - 2);
`else
    localparam logic [TX_CW-1:0] UART_FULL_AT = TX_CW'(TX_DEPTH);
`endif

    logic [7:0] r_ram [2**RAM_ADDR_WIDTH];
    logic [7:0] r_rdata;
    logic       r_uart_full;
    logic       r_sim_end;
    logic       r_tx_overflow;

    acc_t                      w_acc;
    logic [RAM_ADDR_WIDTH-1:0] w_ram_idx;
    logic                      w_req_rd;
    logic                      w_req_wr;
    logic                      w_tx_push;
    logic                      w_tx_pop;
    logic                      w_rx_push;
    logic                      w_rx_pop;
    logic [7:0]                w_rdata_next;
    logic                      w_unused_addr;

    logic [7:0]       w_tx_dout;
    logic [TX_CW-1:0] w_tx_count_unused;
    logic [TX_CW-1:0] w_tx_next_count;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic [7:0]       w_rx_dout;
    logic [RX_CW-1:0] w_rx_count_unused;
    logic [RX_CW-1:0] w_rx_next_count_unused;
    logic             w_rx_full_unused;
    logic             w_rx_empty;

    assign w_unused_addr = ^in_addr[31:18];
    assign w_acc     = decode_acc(in_addr[17:16], in_addr[2:0]);
    assign w_ram_idx = in_addr[RAM_ADDR_WIDTH-1:0];
    assign w_req_rd  = rdy & (in_rw == RW_READ);
    assign w_req_wr  = rdy & (in_rw == RW_WRITE);

    assign w_tx_push = w_req_wr & (w_acc == ACC_UART);
    assign w_tx_pop  = rdy & in_tx_ready;
    assign w_rx_push = rdy & in_rx_valid;
    assign w_rx_pop  = w_req_rd & (w_acc == ACC_UART);

    byte_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_tx_push),
        .i_pop        (w_tx_pop),
        .i_din        (in_wdata),
        .o_dout       (w_tx_dout),
        .o_count      (w_tx_count_unused),
        .o_next_count (w_tx_next_count),
        .o_full       (w_tx_full),
        .o_empty      (w_tx_empty)
    );

    byte_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_rx_push),
        .i_pop        (w_rx_pop),
        .i_din        (in_rx_data),
        .o_dout       (w_rx_dout),
        .o_count      (w_rx_count_unused),
        .o_next_count (w_rx_next_count_unused),
        .o_full       (w_rx_full_unused),
        .o_empty      (w_rx_empty)
    );

    always_comb begin
        w_rdata_next = 8'h00;
        case (w_acc)
            ACC_RAM:    w_rdata_next = r_ram[w_ram_idx];
            ACC_UART:   w_rdata_next = w_rx_empty ? 8'h00 : w_rx_dout;
            ACC_SIMEND: w_rdata_next = {7'b0, r_sim_end};
            default:    w_rdata_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && w_req_wr && (w_acc == ACC_RAM)) begin
            r_ram[w_ram_idx] <= in_wdata;
        end
    end

    // A full TX FIFO with a concurrent pop still takes the push, so only that case is exempt from overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata       <= 8'h00;
            r_uart_full   <= 1'b0;
            r_sim_end     <= 1'b0;
            r_tx_overflow <= 1'b0;
        end else if (rdy) begin
            if (w_req_rd) begin
                r_rdata <= w_rdata_next;
            end
            if (w_req_wr && (w_acc == ACC_SIMEND)) begin
                r_sim_end <= 1'b1;
            end
            if (w_tx_push && w_tx_full && !w_tx_pop) begin
                r_tx_overflow <= 1'b1;
            end
            r_uart_full <= (w_tx_next_count >= UART_FULL_AT);
        end
    end

    assign out_rdata       = r_rdata;
    assign out_uart_full   = r_uart_full;
    assign out_tx_valid    = ~w_tx_empty;
    assign out_tx_data     = w_tx_dout;
    assign out_sim_end     = r_sim_end;
    assign out_tx_overflow = r_tx_overflow;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - directed and randomized checks of mem_io_responder against a queue-based reference model
module tb_mem_io_responder;

    localparam int TX_DEPTH = 8;
    localparam int RX_DEPTH = 8;
`ifdef MEM_IO_UART_LOOKAHEAD_EN
    localparam int FULL_AT = TX_DEPTH - 2;
`else
    localparam int FULL_AT = TX_DEPTH;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_rw;
    logic [31:0] in_addr;
    logic [7:0]  in_wdata;
    logic [7:0]  out_rdata;
    logic        out_uart_full;
    logic        out_tx_valid;
    logic [7:0]  out_tx_data;
    logic        in_tx_ready;
    logic        in_rx_valid;
    logic [7:0]  in_rx_data;
    logic        out_sim_end;
    logic        out_tx_overflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_ram [int];
    logic [7:0] m_tx [$];
    logic [7:0] m_rx [$];
    logic [7:0] m_rdata;
    bit         m_rdata_known;
    bit         m_sim_end;
    bit         m_ovf;

    logic [31:0] pool [4] = '{32'h0000_0010, 32'h0001_FFFF, 32'h0002_0000, 32'hABCD_0123};

    mem_io_responder #(.RAM_ADDR_WIDTH(17), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .in_rw           (in_rw),
        .in_addr         (in_addr),
        .in_wdata        (in_wdata),
        .out_rdata       (out_rdata),
        .out_uart_full   (out_uart_full),
        .out_tx_valid    (out_tx_valid),
        .out_tx_data     (out_tx_data),
        .in_tx_ready     (in_tx_ready),
        .in_rx_valid     (in_rx_valid),
        .in_rx_data      (in_rx_data),
        .out_sim_end     (out_sim_end),
        .out_tx_overflow (out_tx_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        if (m_rdata_known) chk({tag, ".rdata"}, {24'h0, out_rdata}, {24'h0, m_rdata});
        chk({tag, ".tx_valid"}, {31'h0, out_tx_valid}, {31'h0, m_tx.size() > 0});
        if (m_tx.size() > 0) chk({tag, ".tx_data"}, {24'h0, out_tx_data}, {24'h0, m_tx[0]});
        chk({tag, ".uart_full"}, {31'h0, out_uart_full}, {31'h0, m_tx.size() >= FULL_AT});
        chk({tag, ".sim_end"}, {31'h0, out_sim_end}, {31'h0, m_sim_end});
        chk({tag, ".tx_overflow"}, {31'h0, out_tx_overflow}, {31'h0, m_ovf});
    endtask

    // One request cycle: the model applies the documented rules, then DUT outputs are compared after the edge.
    task automatic step(input string tag, input bit v_rdy, input bit v_rw, input logic [31:0] v_addr,
                        input logic [7:0] v_wd, input bit v_rxv, input logic [7:0] v_rxd, input bit v_txr);
        bit is_io;
        int idx;
        rst = 1'b0; rdy = v_rdy; in_rw = v_rw; in_addr = v_addr; in_wdata = v_wd;
        in_rx_valid = v_rxv; in_rx_data = v_rxd; in_tx_ready = v_txr;
        is_io = (v_addr[17:16] == 2'b11);
        idx = int'(v_addr[16:0]);
        if (v_rdy) begin
            if (v_txr && m_tx.size() > 0) void'(m_tx.pop_front());
            if (v_rw) begin
                if (!is_io) m_ram[idx] = v_wd;
                else if (v_addr[2:0] == 3'd0) begin
                    if (m_tx.size() < TX_DEPTH) m_tx.push_back(v_wd);
                    else m_ovf = 1'b1;
                end else if (v_addr[2:0] == 3'd4) m_sim_end = 1'b1;
            end else begin
                m_rdata_known = 1'b1;
                if (!is_io) begin
                    if (m_ram.exists(idx)) m_rdata = m_ram[idx];
                    else m_rdata_known = 1'b0;
                end else if (v_addr[2:0] == 3'd0) m_rdata = (m_rx.size() > 0) ? m_rx.pop_front() : 8'h00;
                else if (v_addr[2:0] == 3'd4) m_rdata = {7'b0, m_sim_end};
                else m_rdata = 8'h00;
            end
            if (v_rxv && m_rx.size() < RX_DEPTH) m_rx.push_back(v_rxd);
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; rdy = 1'b1; in_rw = 1'b1; in_addr = 32'h0003_0000; in_wdata = 8'hEE;
        in_rx_valid = 1'b1; in_rx_data = 8'h77; in_tx_ready = 1'b1;
        m_tx.delete(); m_rx.delete();
        m_rdata = 8'h00; m_rdata_known = 1'b1; m_sim_end = 1'b0; m_ovf = 1'b0;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic idle(input string tag, input bit v_txr);
        step(tag, 1'b1, 1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, v_txr);
    endtask

    initial begin
        do_reset("reset");
        do_reset("reset2");

        // RAM write then read, plus aliasing of the upper address bits
        step("ram_wr", 1, 1, 32'h0000_0010, 8'hA5, 0, 8'h00, 0);
        step("ram_rd", 1, 0, 32'h0000_0010, 8'h00, 0, 8'h00, 0);
        chk("ram_raw", {24'h0, out_rdata}, 32'hA5);
        for (int i = 1; i < 4; i++) begin
            step("pool_wr", 1, 1, pool[i], 8'(8'h30 + i), 0, 8'h00, 0);
            step("pool_rd", 1, 0, pool[i], 8'h00, 0, 8'h00, 0);
        end
        step("alias_rd", 1, 0, 32'h0000_0000, 8'h00, 0, 8'h00, 0);

        // TX fill, overflow, drain in order
        for (int i = 0; i < 8; i++) step("tx_fill", 1, 1, 32'h0003_0000, 8'(8'h10 + i), 0, 8'h00, 0);
        chk("tx_full_after8", {31'h0, out_uart_full}, 32'h1);
        step("tx_ovf", 1, 1, 32'h0003_0000, 8'hFF, 0, 8'h00, 0);
        chk("tx_ovf_flag", {31'h0, out_tx_overflow}, 32'h1);
        for (int i = 0; i < 9; i++) idle("tx_drain", 1);
        chk("tx_drained", {31'h0, out_tx_valid}, 32'h0);

        // Push while full with a concurrent pop
        for (int i = 0; i < 8; i++) step("tx_refill", 1, 1, 32'h0003_0000, 8'(8'h50 + i), 0, 8'h00, 0);
        step("tx_push_pop", 1, 1, 32'h0003_0000, 8'h99, 0, 8'h00, 1);
        for (int i = 0; i < 9; i++) idle("tx_drain2", 1);

        // RX path
        step("rx_push1", 1, 0, 32'h0000_0010, 8'h00, 1, 8'h41, 0);
        step("rx_push2", 1, 0, 32'h0000_0010, 8'h00, 1, 8'h42, 0);
        step("rx_rd1", 1, 0, 32'h0003_0000, 8'h00, 0, 8'h00, 0);
        chk("rx_first", {24'h0, out_rdata}, 32'h41);
        step("rx_rd2", 1, 0, 32'h0003_0000, 8'h00, 0, 8'h00, 0);
        step("rx_rd_empty", 1, 0, 32'h0003_0000, 8'h00, 0, 8'h00, 0);
        step("io_other", 1, 0, 32'h0003_0002, 8'h00, 0, 8'h00, 0);

        // Sim end, sticky
        step("simend_rd0", 1, 0, 32'h0003_0004, 8'h00, 0, 8'h00, 0);
        step("simend_wr", 1, 1, 32'h0003_0004, 8'h01, 0, 8'h00, 0);
        step("simend_rd1", 1, 0, 32'h0003_0004, 8'h00, 0, 8'h00, 0);
        idle("simend_hold", 0);

        // rdy gating
        step("rdy0_push", 0, 1, 32'h0003_0000, 8'hC3, 1, 8'h5A, 1);
        step("rdy0_read", 0, 0, 32'h0000_0010, 8'h00, 1, 8'h5B, 1);

        // Randomized traffic
        for (int n = 0; n < 500; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0, 1:    a = pool[$urandom_range(0, 3)];
                2, 3:    a = 32'h0003_0000;
                4:       a = 32'h0003_0004;
                default: a = 32'h0003_0000 | 32'($urandom_range(1, 7));
            endcase
            step("rand", ($urandom_range(0, 7) != 0), 1'($urandom), a, 8'($urandom),
                 ($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Reset mid-drain
        do_reset("pre_drain_reset");
        for (int i = 0; i < 6; i++) step("fill_lookahead", 1, 1, 32'h0003_0000, 8'(8'hA0 + i), 0, 8'h00, 0);
        idle("drain_a", 1);
        idle("drain_b", 1);
        do_reset("mid_drain_reset");
        chk("reset_tx_valid", {31'h0, out_tx_valid}, 32'h0);
        idle("post_reset", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Byte-serial responder on the RAM side of the memory controller's RAM port.
- Serves one byte per cycle from an internal byte RAM, with read data returned one cycle after the request.
- Decodes the IO region (addr[17:16] == 2'b11) into three functions: a UART TX FIFO, a UART RX FIFO, and a simulation-end register.
- Drives the uart_full flag that the controller uses to stall IO writes.

Parameters:
- RAM_ADDR_WIDTH, 17, byte-address bits of the internal RAM (2^17 bytes).
- TX_DEPTH, 8, UART TX FIFO entries; power of two, at least 4.
- RX_DEPTH, 8, UART RX FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low, no state changes and all outputs hold
- in_rw  in  1  0 = read, 1 = write
- in_addr  in  32  byte address
- in_wdata  in  8  write byte
- out_rdata  out  8  read byte, valid the cycle after a read request
- out_uart_full  out  1  TX FIFO full (or near-full, see Optional Feature)
- out_tx_valid  out  1  TX FIFO head is valid
- out_tx_data  out  8  TX FIFO head byte
- in_tx_ready  in  1  external UART accepts the head byte
- in_rx_valid  in  1  host byte arriving
- in_rx_data  in  8  host byte
- out_sim_end  out  1  sticky; set by a write to IO offset 4
- out_tx_overflow  out  1  sticky; set when a TX write is dropped

Behaviour:
- Reset (rst=1 at a clk edge): out_rdata=0, out_uart_full=0, out_tx_valid=0, out_sim_end=0, out_tx_overflow=0, both FIFOs empty. RAM contents are not reset. Reset overrides rdy and any in-flight request.
- A request is presented every cycle while rdy=1. There is no idle encoding: in_rw=0 is always a read.
- RAM region (addr[17:16] != 2'b11):
  - Write: ram[addr[RAM_ADDR_WIDTH-1:0]] <= in_wdata.
  - Read: out_rdata <= ram[addr] at the next edge.
  - Read-after-write to the same address in the next cycle returns the new byte.
- IO region, decoded on addr[2:0]:
  - Offset 0 write: push in_wdata into the TX FIFO. If TX is full, drop the byte and set out_tx_overflow.
  - Offset 0 read: pop the RX head into out_rdata. If RX is empty, out_rdata <= 0 and no pop occurs.
  - Offset 4 write: out_sim_end <= 1.
  - Offset 4 read: out_rdata <= {7'b0, out_sim_end}.
  - Any other offset: reads return 0; writes are ignored.
- TX FIFO:
  - out_tx_valid = (count != 0); out_tx_data = head byte.
  - Pop when out_tx_valid & in_tx_ready.
  - Simultaneous push and pop with count == TX_DEPTH: both are performed, because the pop is evaluated first; count is unchanged.
  - Head and tail pointers wrap modulo TX_DEPTH. The count is one bit wider than the pointers.
- RX FIFO:
  - Push on in_rx_valid; the byte is dropped if the FIFO is full.
  - Pop and push in the same cycle are both performed.
- out_uart_full is registered from the next-state count: 1 iff next_count >= TX_DEPTH.
- While rdy=0: requests are ignored, FIFO pushes and pops are inhibited, and in_rx_valid is ignored.

Optional Feature:
- Macro: MEM_IO_UART_LOOKAHEAD_EN.
- Defined: out_uart_full = (next_count >= TX_DEPTH-2). This absorbs the controller's 2-cycle stall window so that no write is ever dropped.
- Undefined: out_uart_full = (next_count >= TX_DEPTH), as specified above.

Decomposition:
- Shared package / constant header holds:
  - IO_REGION = 2'b11
  - IO_OFS_UART = 3'd0
  - IO_OFS_SIMEND = 3'd4
  - RW_READ = 0
  - RW_WRITE = 1
- One natural sub-module, byte_fifo (parameters DEPTH and WIDTH = 8; ports push, pop, din, dout, count, full, empty). It is instantiated for both TX and RX.
- RAM array and address decode stay in the top level.

Test Plan:
- RAM write then read: write 0xA5 to 0x00010, read 0x00010 the next cycle -> out_rdata == 0xA5 one cycle after the read.
- TX fill with in_tx_ready=0:
  - Write 8 bytes to 0x30000 -> out_uart_full=1 after the 8th.
  - 9th write -> dropped, out_tx_overflow=1.
  - Raise in_tx_ready -> bytes drain in order, out_tx_valid falls after 8 cycles.
- TX push while full with in_tx_ready=1 in the same cycle -> count stays 8, the new byte appears last in drain order.
- RX path:
  - Pulse in_rx_valid with 0x41, then 0x42; read 0x30000 twice -> 0x41 then 0x42.
  - A third read -> 0x00.
- Sim end: write 0x30004 -> out_sim_end=1, sticky until rst; read 0x30004 -> 0x01.
- rdy gating and reset:
  - With rdy=0, write 0x30000 -> no push, outputs hold.
  - Assert rst mid-drain -> FIFOs empty, out_tx_valid=0 the next cycle.
  - With MEM_IO_UART_LOOKAHEAD_EN defined, out_uart_full=1 at count 6.
